// File: rtl/rvsteel_bus_copy_engine.sv
// rvsteel_bus_copy_engine
// Block copy initiator for the RISC-V Steel core IO bus. It copies one 32-bit word
// at a time: read from src, write to dst, step both by 4, repeat until the count
// runs out or an abort has been seen.
//
// Optional feature macro: RVSTEEL_COPY_TIMEOUT_EN
//   defined   -> a response watchdog of TIMEOUT_CYCLES cycles drops a stuck
//                request, sets the sticky error flag and finishes the transfer.
//   undefined -> no watchdog; error is tied low and the engine waits forever.
//
// state | meaning
// IDLE  | waiting for start; no requests on the bus
// READ  | read_request held at src until read_response
// WRITE | write_request held at dst with the buffered word until write_response
// DONE  | one-cycle done pulse with busy still high, then back to IDLE

module rvsteel_bus_copy_engine #(
  parameter int LENGTH_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             src_address,
  input  logic [31:0]             dst_address,
  input  logic [LENGTH_WIDTH-1:0] word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [LENGTH_WIDTH-1:0] words_done,
  output logic [31:0]             rw_address,
  input  logic [31:0]             read_data,
  output logic                    read_request,
  input  logic                    read_response,
  output logic [31:0]             write_data,
  output logic [3:0]              write_strobe,
  output logic                    write_request,
  input  logic                    write_response
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LENGTH_WIDTH-1:0] ONE_WORD   = LENGTH_WIDTH'(1);
  localparam logic [31:0]             WORD_STEP  = 32'd4;
  localparam logic [31:0]             ALIGN_MASK = 32'hFFFF_FFFC;

  state_t                  state_q, state_d;
  logic [31:0]             src_q, src_d;
  logic [31:0]             dst_q, dst_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic [LENGTH_WIDTH-1:0] words_done_q, words_done_d;
  logic                    abort_seen_q, abort_seen_d;
  logic [31:0]             rw_address_q, rw_address_d;
  logic [31:0]             write_data_q, write_data_d;
  logic                    read_request_q, read_request_d;
  logic                    write_request_q, write_request_d;
  logic [3:0]              write_strobe_q, write_strobe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    last_word;
  logic                    stop_after_write;

`ifdef RVSTEEL_COPY_TIMEOUT_EN
  localparam int                TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               error_q, error_d;
  logic               timer_expired;
`else
  logic               unused_timeout_cfg;
`endif

  // The write now completing is the final one, either by count or by a pending abort.
  // abort is folded in directly so a pulse landing on the response cycle still counts.
  always_comb begin
    last_word        = ((words_done_q + ONE_WORD) == count_q);
    stop_after_write = last_word | abort_seen_q | abort;
  end

`ifdef RVSTEEL_COPY_TIMEOUT_EN
  // Watchdog terminal count: this cycle is the TIMEOUT_CYCLES-th without a response.
  always_comb begin
    timer_expired = (timer_q == TIMER_LAST);
  end
`endif

  // Next-state and registered-output computation; every output is a flop.
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    count_d         = count_q;
    words_done_d    = words_done_q;
    abort_seen_d    = abort_seen_q;
    rw_address_d    = rw_address_q;
    write_data_d    = write_data_q;
    read_request_d  = read_request_q;
    write_request_d = write_request_q;
    write_strobe_d  = write_strobe_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
`ifdef RVSTEEL_COPY_TIMEOUT_EN
    timer_d         = timer_q;
    error_d         = error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_address & ALIGN_MASK;
          dst_d        = dst_address & ALIGN_MASK;
          count_d      = word_count;
          words_done_d = '0;
          abort_seen_d = 1'b0;
          busy_d       = 1'b1;
`ifdef RVSTEEL_COPY_TIMEOUT_EN
          error_d      = 1'b0;
          timer_d      = '0;
`endif
          if (word_count != '0) begin
            state_d        = READ;
            rw_address_d   = src_address & ALIGN_MASK;
            read_request_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      READ: begin
        abort_seen_d = abort_seen_q | abort;
        if (read_response) begin
          write_data_d    = read_data;
          read_request_d  = 1'b0;
          write_request_d = 1'b1;
          rw_address_d    = dst_q;
          write_strobe_d  = 4'b1111;
          state_d         = WRITE;
`ifdef RVSTEEL_COPY_TIMEOUT_EN
          timer_d         = '0;
`endif
        end
`ifdef RVSTEEL_COPY_TIMEOUT_EN
        else if (timer_expired) begin
          read_request_d = 1'b0;
          error_d        = 1'b1;
          state_d        = DONE;
          done_d         = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end

      WRITE: begin
        abort_seen_d = abort_seen_q | abort;
        if (write_response) begin
          words_done_d    = words_done_q + ONE_WORD;
          src_d           = src_q + WORD_STEP;
          dst_d           = dst_q + WORD_STEP;
          write_request_d = 1'b0;
          write_strobe_d  = 4'b0000;
          if (stop_after_write) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d        = READ;
            rw_address_d   = src_q + WORD_STEP;
            read_request_d = 1'b1;
`ifdef RVSTEEL_COPY_TIMEOUT_EN
            timer_d        = '0;
`endif
          end
        end
`ifdef RVSTEEL_COPY_TIMEOUT_EN
        else if (timer_expired) begin
          write_request_d = 1'b0;
          write_strobe_d  = 4'b0000;
          error_d         = 1'b1;
          state_d         = DONE;
          done_d          = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      count_q         <= '0;
      words_done_q    <= '0;
      abort_seen_q    <= 1'b0;
      rw_address_q    <= '0;
      write_data_q    <= '0;
      read_request_q  <= 1'b0;
      write_request_q <= 1'b0;
      write_strobe_q  <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      count_q         <= count_d;
      words_done_q    <= words_done_d;
      abort_seen_q    <= abort_seen_d;
      rw_address_q    <= rw_address_d;
      write_data_q    <= write_data_d;
      read_request_q  <= read_request_d;
      write_request_q <= write_request_d;
      write_strobe_q  <= write_strobe_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

`ifdef RVSTEEL_COPY_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign error              = 1'b0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign words_done    = words_done_q;
  assign rw_address    = rw_address_q;
  assign read_request  = read_request_q;
  assign write_request = write_request_q;
  assign write_data    = write_data_q;
  assign write_strobe  = write_strobe_q;

endmodule
